// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: writes into an external dual-port RAM and
// reads it back through a 2-entry output buffer to hide the RAM read latency.
module sync_fifo_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WIDTH-1:0]             s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_data,
  output logic [$clog2(DEPTH+3)-1:0]   level,
  output logic                         ram_ena,
  output logic                         ram_wea,
  output logic [$clog2(DEPTH)-1:0]     ram_addra,
  output logic [WIDTH-1:0]             ram_dina,
  output logic                         ram_enb,
  output logic                         ram_web,
  output logic [$clog2(DEPTH)-1:0]     ram_addrb,
  input  logic [WIDTH-1:0]             ram_doutb
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(DEPTH + 3);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic [1:0]       ob_cnt_q, ob_cnt_d;
  logic [WIDTH-1:0] ob_q [2];
  logic [WIDTH-1:0] ob_d [2];

  logic       push, pop, issue;
  logic [2:0] ob_after;
  logic       ob_wr_idx;

  // Handshakes and RAM port drive; everything is forced to 0 while in reset.
  always_comb begin
    s_ready   = !rst && (ram_cnt_q < CW'(DEPTH));
    push      = s_valid && s_ready;
    m_valid   = !rst && (ob_cnt_q != 2'd0);
    m_data    = m_valid ? ob_q[0] : '0;
    pop       = m_valid && m_ready;
    // Buffer occupancy once the in-flight read lands and this cycle's pop leaves.
    ob_after  = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    issue     = !rst && (ram_cnt_q != '0) && (ob_after < 3'd2);

    ram_ena   = push;
    ram_wea   = push;
    ram_addra = push ? wr_ptr_q : '0;
    ram_dina  = push ? s_data : '0;
    ram_enb   = issue;
    ram_web   = 1'b0;
    ram_addrb = issue ? rd_ptr_q : '0;

    level     = rst ? '0 : LW'(ram_cnt_q) + LW'(rd_pend_q) + LW'(ob_cnt_q);
  end

  // NOTE: every variable gets its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(issue);
    ram_cnt_d = ram_cnt_q + CW'(push) - CW'(issue);
    rd_pend_d = issue;
    ob_cnt_d  = ob_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    ob_d[0]   = ob_q[0];
    ob_d[1]   = ob_q[1];
    // A landing read never meets a full buffer, so the tail is slot 0 or 1.
    ob_wr_idx = ob_cnt_q[0] && !pop;
    if (pop) begin
      ob_d[0] = ob_q[1];
    end
    if (rd_pend_q) begin
      ob_d[ob_wr_idx] = ram_doutb;
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample
  // the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      ob_cnt_q  <= '0;
      // NOTE: the two buffer entries are plain registers and are cleared; the
      // external RAM array is left untouched.
      ob_q[0]   <= '0;
      ob_q[1]   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      ob_cnt_q  <= ob_cnt_d;
      ob_q[0]   <= ob_d[0];
      ob_q[1]   <= ob_d[1];
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: stimulus queues accepted words, a
// monitor process pops them as they leave and checks occupancy and RAM traffic.
module tb_sync_fifo_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              s_valid, s_ready;
  logic [WIDTH-1:0]  s_data;
  logic              m_valid, m_ready;
  logic [WIDTH-1:0]  m_data;
  logic [2:0]        level;
  logic              ram_ena, ram_wea, ram_enb, ram_web;
  logic [1:0]        ram_addra, ram_addrb;
  logic [WIDTH-1:0]  ram_dina, ram_doutb;

  sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  // Behavioural dual-port RAM, one-cycle read latency.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               held = 0;
  int               wr_cnt = 0;
  int               rd_cnt = 0;
  logic [1:0]       prev_addra = 2'd0, prev_addrb = 2'd0;
  logic             wrap_a = 1'b0, wrap_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; returns at the following negedge.
  task automatic drive(input logic r, input logic sv, input logic [31:0] sd,
                       input logic mr, output logic acc);
    @(posedge clk);
    #1;
    rst = r; s_valid = sv; s_data = sd; m_ready = mr;
    @(negedge clk);
    acc = sv && s_ready && !r;
    if (acc) exp_q.push_back(sd);
  endtask

  task automatic monitor();
    logic push_o, pop_o;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_level", level, 0);
        check("rst_ram_a", {ram_ena, ram_wea, ram_addra}, 0);
        check("rst_ram_dina", ram_dina, 0);
        check("rst_ram_b", {ram_enb, ram_addrb}, 0);
        exp_q.delete();
        held = 0; wr_cnt = 0; rd_cnt = 0;
      end else begin
        push_o = s_valid && s_ready;
        pop_o  = m_valid && m_ready;
        check("level", level, held);
        if (held == 0) check("empty_m_valid", m_valid, 0);
        check("ram_wea", ram_wea, push_o);
        check("ram_web", ram_web, 0);
        if (ram_wea) begin
          check("ram_ena", ram_ena, 1);
          check("ram_addra", ram_addra, wr_cnt % DEPTH);
          check("ram_dina", ram_dina, s_data);
          if (prev_addra == 2'd3 && ram_addra == 2'd0) wrap_a = 1'b1;
          prev_addra = ram_addra;
          wr_cnt++;
        end
        if (ram_enb) begin
          check("ram_addrb", ram_addrb, rd_cnt % DEPTH);
          if (prev_addrb == 2'd3 && ram_addrb == 2'd0) wrap_b = 1'b1;
          prev_addrb = ram_addrb;
          rd_cnt++;
        end
        if (pop_o) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL sb_underflow: got 0x%0h, expected no word at %0t", m_data, $time);
          end else begin
            check("sb_data", m_data, exp_q.pop_front());
          end
        end
        held = held + int'(push_o) - int'(pop_o);
      end
    end
  endtask

  initial begin
    logic acc;
    int   n_acc;
    logic [31:0] word;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    fork
      monitor();
    join_none

    // Reset with random inputs, then ready on the first free cycle.
    for (int i = 0; i < 2; i++) drive(1'b1, 1'($urandom), $urandom, 1'($urandom), acc);
    drive(1'b0, 1'b0, 32'h0, 1'b0, acc);
    check("ready_after_rst", s_ready, 1);

    // Single word: three-cycle latency, level counts it from the next cycle.
    drive(1'b0, 1'b1, 32'h0000_00A5, 1'b0, acc);
    check("single_acc", acc, 1);
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, acc);
      check("single_level", level, 1);
      check("single_m_valid", m_valid, c == 3);
    end
    check("single_m_data", m_data, 32'h0000_00A5);
    drive(1'b0, 1'b0, 32'h0, 1'b1, acc);
    drive(1'b0, 1'b0, 32'h0, 1'b0, acc);

    // Fill to capacity with downstream stalled, then drain in order.
    n_acc = 0;
    word  = 32'd1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, word, 1'b0, acc);
      if (acc) begin n_acc++; word++; end
    end
    check("fill_count", n_acc, 6);
    check("fill_s_ready", s_ready, 0);
    check("fill_level", level, 6);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, acc);
      check("drain_m_valid", m_valid, 1);
      check("drain_m_data", m_data, i);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, acc);
    check("drain_empty", m_valid, 0);

    // Streaming: one word per cycle, output lags input by three cycles.
    for (int c = 0; c < 23; c++) begin
      drive(1'b0, c < 20, c, 1'b1, acc);
      if (c < 20) check("stream_acc", acc, 1);
      if (c >= 3) begin
        check("stream_m_valid", m_valid, 1);
        check("stream_m_data", m_data, c - 3);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, acc);

    // Mid-operation reset drops held words.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h100 + i, 1'b0, acc);
    drive(1'b1, 1'b0, 32'h0, 1'b0, acc);
    drive(1'b0, 1'b0, 32'h0, 1'b0, acc);
    check("mid_rst_level", level, 0);
    check("mid_rst_m_valid", m_valid, 0);
    drive(1'b0, 1'b1, 32'h77, 1'b1, acc);
    for (int c = 1; c <= 3; c++) drive(1'b0, 1'b0, 32'h0, 1'b1, acc);
    check("post_rst_m_valid", m_valid, 1);
    check("post_rst_first", m_data, 32'h77);
    drive(1'b0, 1'b0, 32'h0, 1'b0, acc);

    // Random traffic across pointer wrap, then drain.
    for (int i = 0; i < 200; i++) drive(1'b0, 1'($urandom), $urandom, 1'($urandom), acc);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 32'h0, 1'b1, acc);
    check("final_sb_empty", exp_q.size(), 0);
    check("final_level", level, 0);
    check("wrap_addra", wrap_a, 1);
    check("wrap_addrb", wrap_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Purpose: single-clock FIFO controller that drives a dual-port RAM instance (write on port A, read on port B) and presents valid/ready streams on both sides.

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 32, data width.
- DEPTH, default 4, RAM entries; power of 2, at least 2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, synchronous, active-high reset.
- s_valid, in, 1, upstream word offered.
- s_ready, out, 1, controller can accept.
- s_data, in, WIDTH, upstream word.
- m_valid, out, 1, downstream word available.
- m_ready, in, 1, downstream accepts.
- m_data, out, WIDTH, downstream word.
- level, out, $clog2(DEPTH+3), words held.
- ram_ena, out, 1, RAM port A enable.
- ram_wea, out, 1, RAM port A write enable.
- ram_addra, out, $clog2(DEPTH), RAM port A address.
- ram_dina, out, WIDTH, RAM port A write data.
- ram_enb, out, 1, RAM port B enable.
- ram_web, out, 1, RAM port B write enable; tied 0.
- ram_addrb, out, $clog2(DEPTH), RAM port B address.
- ram_doutb, in, WIDTH, RAM port B read data; valid 1 cycle after ram_enb.

Function
REQ-003 Internal state SHALL be:
- wr_ptr, rd_ptr: $clog2(DEPTH) bits, wrap modulo DEPTH.
- ram_cnt: 0..DEPTH.
- rd_pend: 1 bit, a read was issued last cycle.
- Output buffer OB: 2 entries, count ob_cnt 0..2.
REQ-004 s_ready SHALL equal (ram_cnt < DEPTH) AND NOT rst.
REQ-005 push = s_valid & s_ready. On push, in the same cycle, the controller SHALL drive ram_ena=1, ram_wea=1, ram_addra=wr_ptr and ram_dina=s_data, then increment wr_ptr.
REQ-006 ram_ena and ram_wea SHALL be 0 when push is 0.
REQ-007 pop = m_valid & m_ready. m_valid SHALL equal (ob_cnt > 0), and m_data SHALL be the OB head entry.
REQ-008 issue SHALL be asserted when ram_cnt > 0 AND (ob_cnt + rd_pend - pop) < 2. On issue the controller SHALL drive ram_enb=1 and ram_addrb=rd_ptr, then increment rd_ptr. rd_pend SHALL be registered from issue.
REQ-009 When rd_pend=1, ram_doutb SHALL be written into the OB tail that cycle. A simultaneous pop SHALL advance the OB head in the same cycle.
REQ-010 ram_cnt SHALL take next value ram_cnt + push - issue; a simultaneous push and issue SHALL leave it unchanged.
REQ-011 level SHALL equal ram_cnt + rd_pend + ob_cnt; total capacity SHALL be DEPTH+2.
REQ-012 Latency: a word pushed in cycle t with an empty FIFO SHALL appear on m_valid/m_data in cycle t+3.
REQ-013 With s_valid=1 and m_ready=1 held, throughput SHALL be 1 word per cycle with no bubbles after the initial latency.
REQ-014 The controller SHALL never issue a read of an address being written in the same cycle, since issue requires ram_cnt > 0 from prior writes. RAM read-during-write semantics therefore never matter.
REQ-015 Order SHALL be strictly first-in first-out across pointer wrap-around.
REQ-016 When full (ram_cnt=DEPTH), s_ready SHALL be 0 and s_data SHALL be ignored. When empty (level=0), m_valid SHALL be 0 and m_ready SHALL be ignored.

Reset
REQ-017 While rst=1, the following SHALL be cleared to 0 at each posedge: wr_ptr, rd_ptr, ram_cnt, rd_pend, ob_cnt, and both OB entries.
REQ-018 While rst=1, all outputs SHALL be 0: s_ready, m_valid, m_data, level, ram_ena, ram_wea, ram_enb, ram_addra, ram_addrb, ram_dina.
REQ-019 A reset asserted mid-operation SHALL discard all held words. Any ram_doutb returning from a read issued before reset SHALL be ignored. RAM contents SHALL NOT be cleared.

Verification (DEPTH=4, WIDTH=32)
REQ-020 Reset: hold rst 2 cycles with random inputs -> all outputs 0; s_ready=1 in the first cycle after rst falls.
REQ-021 Single word: push 0x000000A5 in cycle 0 with m_ready=0 -> m_valid=1 and m_data=0xA5 from cycle 3; level=1 from cycle 1.
REQ-022 Fill: m_ready=0, s_valid=1 with 1,2,3,...:
- Exactly 6 words are accepted; s_ready=0 thereafter; level=6.
- Then m_ready=1 -> words 1..6 come out in order, one per cycle.
REQ-023 Stream: s_valid=1 and m_ready=1 for words 0..19 -> outputs 0..19 in order on consecutive cycles starting 3 cycles after the first push.
REQ-024 Reset mid-operation: with 3 words held, pulse rst 1 cycle -> level=0 and m_valid=0. A subsequent push of 0x77 is the first word out.
REQ-025 Wrap and random: 200 cycles of random s_valid/m_ready -> output equals input order (scoreboard). ram_addra/ram_addrb wrap 3->0. ram_wea is never 1 while s_ready=0.
